// File: rtl/pc_fetch_if.sv
// Instruction-fetch bus between the PC/fetch sequencer (master) and instruction memory (slave).
interface pc_fetch_if #(
    parameter int XLEN = 32
);
    logic            ifu_req_valid;
    logic [XLEN-1:0] ifu_req_addr;
    logic            ifu_req_ready;
    logic            ifu_rsp_valid;
    logic [31:0]     ifu_rsp_inst;

    modport master (
        output ifu_req_valid,
        output ifu_req_addr,
        input  ifu_req_ready,
        input  ifu_rsp_valid,
        input  ifu_rsp_inst
    );

    modport slave (
        input  ifu_req_valid,
        input  ifu_req_addr,
        output ifu_req_ready,
        output ifu_rsp_valid,
        output ifu_rsp_inst
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer: BOOT -> FETCH -> WAIT -> EXEC -> FETCH, terminal HALT/ERR.
// Optional PC_FETCH_TRACE_EN adds prev_pc and a 64-bit instret counter.
module pc_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_fetch_if.master       ifu,
    output logic             inst_valid,
    output logic [31:0]      inst,
    output logic [XLEN-1:0]  pc,
    input  logic             commit_valid,
    input  logic [1:0]       pc_src,
    input  logic [XLEN-1:0]  jump_target,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             halt_req,
    output logic             misalign_err,
    output logic             halted
`ifdef PC_FETCH_TRACE_EN
    ,
    output logic [XLEN-1:0]  prev_pc,
    output logic [63:0]      instret
`endif
);

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic            misalign_q, misalign_d;
    logic            req_valid_q;
    logic            inst_valid_q;
    logic            halted_q;
    logic            retire_s;
    logic [XLEN-1:0] next_pc_s;

    // Candidate next PC from the PC-source code; JALR clears bit 0 before the alignment check.
    always_comb begin
        next_pc_s = pc_q + XLEN'(32'd4);
        case (pc_src)
            2'b00:   next_pc_s = pc_q + XLEN'(32'd4);
            2'b01:   next_pc_s = jump_target;
            2'b10:   next_pc_s = {alu_result[XLEN-1:1], 1'b0};
            2'b11:   next_pc_s = pc_q + XLEN'(32'd4);
            default: next_pc_s = pc_q + XLEN'(32'd4);
        endcase
    end

    // Next-state and datapath update for the fetch sequencer.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        misalign_d = misalign_q;
        retire_s   = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH: begin
                if (ifu.ifu_req_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (ifu.ifu_rsp_valid) begin
                    inst_d  = ifu.ifu_rsp_inst;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_EXEC: begin
                if (!commit_valid) begin
                    state_d = ST_EXEC;
                end else if (halt_req) begin
                    state_d  = ST_HALT;
                    retire_s = 1'b1;
                end else if (next_pc_s[1:0] != 2'b00) begin
                    state_d    = ST_ERR;
                    misalign_d = 1'b1;
                end else begin
                    pc_d     = next_pc_s;
                    state_d  = ST_FETCH;
                    retire_s = 1'b1;
                end
            end
            ST_HALT: state_d = ST_HALT;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    // State, PC, instruction and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0000_0000;
            misalign_q   <= 1'b0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            misalign_q   <= misalign_d;
            req_valid_q  <= (state_d == ST_FETCH);
            inst_valid_q <= (state_q == ST_WAIT) && (state_d == ST_EXEC);
            halted_q     <= halted_q || (state_d == ST_HALT) || (state_d == ST_ERR);
        end
    end

`ifdef PC_FETCH_TRACE_EN
    logic [XLEN-1:0] prev_pc_q;
    logic [63:0]     instret_q;

    // Trace: remember the retiring PC and count commits that advance or halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_pc_q <= '0;
            instret_q <= 64'd0;
        end else if (retire_s) begin
            prev_pc_q <= pc_q;
            instret_q <= instret_q + 64'd1;
        end else begin
            prev_pc_q <= prev_pc_q;
            instret_q <= instret_q;
        end
    end

    assign prev_pc = prev_pc_q;
    assign instret = instret_q;
`endif

    assign ifu.ifu_req_valid = req_valid_q;
    assign ifu.ifu_req_addr  = pc_q;
    assign inst_valid        = inst_valid_q;
    assign inst              = inst_q;
    assign pc                = pc_q;
    assign misalign_err      = misalign_q;
    assign halted            = halted_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized scoreboard bench for pc_fetch_unit: stimulus pushes expected fetch addresses and
// instructions; a negedge monitor pops and compares on every accepted request and inst_valid pulse.
module tb_pc_fetch_unit;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        commit_valid = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] jump_target = 32'h0;
    logic [31:0] alu_result = 32'h0;
    logic        halt_req = 1'b0;
    logic        misalign_err;
    logic        halted;
`ifdef PC_FETCH_TRACE_EN
    logic [31:0] prev_pc;
    logic [63:0] instret;
`endif

    pc_fetch_if #(.XLEN(XLEN)) bus ();

    pc_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h8000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ifu          (bus.master),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .pc           (pc),
        .commit_valid (commit_valid),
        .pc_src       (pc_src),
        .jump_target  (jump_target),
        .alu_result   (alu_result),
        .halt_req     (halt_req),
        .misalign_err (misalign_err),
        .halted       (halted)
`ifdef PC_FETCH_TRACE_EN
        ,
        .prev_pc      (prev_pc),
        .instret      (instret)
`endif
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_inst_q[$];

    // Architectural reference state
    logic [31:0]     model_pc;
    logic            model_dead;
    logic            model_err;
    logic [31:0]     model_prev;
    longint unsigned model_instret;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [1:0] s, input logic [31:0] p,
                                               input logic [31:0] jt, input logic [31:0] alu);
        if (s == 2'b01) return jt;
        if (s == 2'b10) return alu & 32'hFFFF_FFFE;
        return p + 32'd4;
    endfunction

    // Monitor: every accepted request and every inst_valid pulse consumes one expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ifu_req_valid && bus.ifu_req_ready) begin
                if (exp_addr_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL unexpected_req: got addr %h, expected no request", bus.ifu_req_addr);
                end else begin
                    check("req_addr", bus.ifu_req_addr, exp_addr_q.pop_front());
                end
            end
            if (inst_valid) begin
                if (exp_inst_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL unexpected_inst_valid: got inst %h, expected no pulse", inst);
                end else begin
                    check("inst_out", inst, exp_inst_q.pop_front());
                end
            end
        end
    end

    task automatic clear_inputs();
        bus.ifu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b0;
        bus.ifu_rsp_inst  = 32'h0;
        commit_valid = 1'b0;
        halt_req     = 1'b0;
        pc_src       = 2'b00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        exp_addr_q.delete();
        exp_inst_q.delete();
        model_pc = 32'h8000_0000; model_dead = 1'b0; model_err = 1'b0;
        model_prev = 32'h0; model_instret = 0;
        @(posedge clk); #1;
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_inst", inst, 32'h0);
        check("rst_req_valid", bus.ifu_req_valid, 1'b0);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_halted", {misalign_err, halted}, 2'b00);
        rst_n = 1'b1;
        exp_addr_q.push_back(32'h8000_0000);
        check("boot_no_req", bus.ifu_req_valid, 1'b0);
        @(posedge clk); #1;
        check("first_req_valid", bus.ifu_req_valid, 1'b1);
        check("first_req_addr", bus.ifu_req_addr, 32'h8000_0000);
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (!bus.ifu_req_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        ok = bus.ifu_req_valid;
        check("req_valid_wait", bus.ifu_req_valid, 1'b1);
    endtask

    task automatic do_instr(input logic [1:0] s, input logic [31:0] jt, input logic [31:0] alu,
                            input logic hlt, input logic [31:0] iw);
        bit          ok;
        int          n;
        logic [31:0] nxt;
        wait_req(ok);
        if (!ok) return;
        // Backpressure with stray response/commit traffic that FETCH must ignore
        n = $urandom_range(0, 5);
        for (int i = 0; i < n; i++) begin
            bus.ifu_rsp_valid = 1'($urandom_range(0, 1));
            bus.ifu_rsp_inst  = $urandom;
            commit_valid      = 1'($urandom_range(0, 1));
            halt_req          = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("req_hold_valid", bus.ifu_req_valid, 1'b1);
            check("req_hold_addr", bus.ifu_req_addr, model_pc);
        end
        commit_valid = 1'b0; halt_req = 1'b0;
        // Response in the acceptance cycle must not be consumed
        bus.ifu_req_ready = 1'b1; bus.ifu_rsp_valid = 1'b1; bus.ifu_rsp_inst = ~iw;
        @(posedge clk); #1;
        bus.ifu_req_ready = 1'b0; bus.ifu_rsp_valid = 1'b0;
        check("req_drop_after_accept", bus.ifu_req_valid, 1'b0);
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
        exp_inst_q.push_back(iw);
        bus.ifu_rsp_valid = 1'b1; bus.ifu_rsp_inst = iw;
        @(posedge clk); #1;
        bus.ifu_rsp_valid = 1'b0;
        check("inst_capture", inst, iw);
        check("inst_valid_pulse", inst_valid, 1'b1);
        // EXEC dwell with stray responses and halt_req lacking commit
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
            bus.ifu_rsp_valid = 1'($urandom_range(0, 1));
            bus.ifu_rsp_inst  = $urandom;
            halt_req          = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("inst_hold", inst, iw);
            check("exec_no_req", bus.ifu_req_valid, 1'b0);
        end
        bus.ifu_rsp_valid = 1'b0;
        nxt = model_next(s, model_pc, jt, alu);
        pc_src = s; jump_target = jt; alu_result = alu; halt_req = hlt; commit_valid = 1'b1;
        if (hlt) begin
            model_dead = 1'b1; model_prev = model_pc; model_instret++;
        end else if (nxt[1:0] != 2'b00) begin
            model_dead = 1'b1; model_err = 1'b1;
        end else begin
            model_prev = model_pc; model_pc = nxt; model_instret++;
            exp_addr_q.push_back(nxt);
        end
        @(posedge clk); #1;
        commit_valid = 1'b0; halt_req = 1'b0;
        check("pc_after_commit", pc, model_pc);
        check("req_after_commit", bus.ifu_req_valid, !model_dead);
        check("halted", halted, model_dead);
        check("misalign_err", misalign_err, model_err);
`ifdef PC_FETCH_TRACE_EN
        check("prev_pc", prev_pc, model_prev);
        check("instret", instret, model_instret);
`endif
    endtask

    task automatic terminal_check();
        bus.ifu_req_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.ifu_rsp_valid = 1'($urandom_range(0, 1));
            commit_valid      = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("terminal_no_req", bus.ifu_req_valid, 1'b0);
            check("terminal_pc", pc, model_pc);
            check("terminal_halted", halted, 1'b1);
        end
        clear_inputs();
    endtask

    task automatic rand_instr();
        logic [31:0] r1, r2, jt, alu;
        r1 = $urandom; r2 = $urandom;
        jt  = {r1[31:2], 2'b00};
        alu = r2 & 32'hFFFF_FFFD;
        do_instr(2'($urandom_range(0, 3)), jt, alu, 1'b0, $urandom);
    endtask

    initial begin
        bit ok;
        do_reset();
        do_instr(2'b00, 32'h0, 32'h0, 1'b0, 32'h0000_0013);
        do_instr(2'b01, 32'h8000_0100, 32'h0, 1'b0, $urandom);
        do_instr(2'b10, 32'h0, 32'h8000_0201, 1'b0, $urandom);
        do_instr(2'b11, 32'h1234_5672, 32'h0, 1'b0, $urandom);
        for (int k = 0; k < 20; k++) rand_instr();
        do_instr(2'b01, 32'hFFFF_FFFC, 32'h0, 1'b0, $urandom);
        do_instr(2'b00, 32'h0, 32'h0, 1'b0, $urandom);
        check("wrap_pc", pc, 32'h0);
        do_instr(2'b01, 32'h8000_0040, 32'h0, 1'b1, 32'h0010_0073);
        terminal_check();

        // Asynchronous reset while waiting for a response
        do_reset();
        do_instr(2'b00, 32'h0, 32'h0, 1'b0, 32'hDEAD_BEEF);
        wait_req(ok);
        bus.ifu_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.ifu_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pc", pc, 32'h8000_0000);
        check("async_rst_inst", inst, 32'h0);
        check("async_rst_req", bus.ifu_req_valid, 1'b0);
        check("async_rst_flags", {inst_valid, misalign_err, halted}, 3'b000);

        // Misaligned JALR target
        do_reset();
        do_instr(2'b10, 32'h0, 32'h8000_0006, 1'b0, $urandom);
        terminal_check();

        // Misaligned JAL target after a few random commits
        do_reset();
        for (int k = 0; k < 3; k++) rand_instr();
        do_instr(2'b01, 32'h8000_0102, 32'h0, 1'b0, $urandom);
        terminal_check();

        check("addr_queue_drained", 64'(exp_addr_q.size()), 64'd0);
        check("inst_queue_drained", 64'(exp_inst_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
